// File: rtl/process_noise_q_builder.sv
// Builds the 6 unique entries of the symmetric process-noise matrix Q = sigma2*G*G^T
// by routing each latched dt-power coefficient through the shared FP64 multiplier.
module process_noise_q_builder #(
  parameter int DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_coef_valid,
  input  logic [DWIDTH-1:0] i_sigma2,
  input  logic [DWIDTH-1:0] i_thirtysix_dt6,
  input  logic [DWIDTH-1:0] i_twleve_dt5,
  input  logic [DWIDTH-1:0] i_sixth_dt4,
  input  logic [DWIDTH-1:0] i_quarter_dt4,
  input  logic [DWIDTH-1:0] i_half_dt3,
  input  logic [DWIDTH-1:0] i_dt2,
  output logic              o_mul_req_valid,
  input  logic              i_mul_req_ready,
  output logic [DWIDTH-1:0] o_mul_req_a,
  output logic [DWIDTH-1:0] o_mul_req_b,
  input  logic              i_mul_resp_valid,
  output logic              o_mul_resp_ready,
  input  logic [DWIDTH-1:0] i_mul_resp_y,
  output logic [DWIDTH-1:0] o_q00,
  output logic [DWIDTH-1:0] o_q01,
  output logic [DWIDTH-1:0] o_q02,
  output logic [DWIDTH-1:0] o_q10,
  output logic [DWIDTH-1:0] o_q11,
  output logic [DWIDTH-1:0] o_q12,
  output logic [DWIDTH-1:0] o_q20,
  output logic [DWIDTH-1:0] o_q21,
  output logic [DWIDTH-1:0] o_q22,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_valid
);
  localparam int NQ = 6;

  // REQ states are odd, WAIT states even; entry index = (state-1)/2
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_REQ_Q00  = 4'd1,  S_WAIT_Q00 = 4'd2,
    S_REQ_Q01  = 4'd3,  S_WAIT_Q01 = 4'd4,
    S_REQ_Q02  = 4'd5,  S_WAIT_Q02 = 4'd6,
    S_REQ_Q11  = 4'd7,  S_WAIT_Q11 = 4'd8,
    S_REQ_Q12  = 4'd9,  S_WAIT_Q12 = 4'd10,
    S_REQ_Q22  = 4'd11, S_WAIT_Q22 = 4'd12
  } state_t;

  state_t                       r_state;
  logic [NQ-1:0][DWIDTH-1:0]    r_coef;
  logic [NQ-1:0][DWIDTH-1:0]    r_q;
  logic [DWIDTH-1:0]            r_sigma2;
  logic                         r_done;
  logic                         r_valid;

  logic                         w_legal;
  logic                         w_is_req;
  logic                         w_is_wait;
  logic [2:0]                   w_step;
  logic [3:0]                   w_sm1;
  logic                         w_req_fire;
  logic                         w_resp_fire;

  assign w_legal     = (r_state != S_IDLE) && (r_state <= S_WAIT_Q22);
  assign w_is_req    = w_legal &&  r_state[0];
  assign w_is_wait   = w_legal && !r_state[0];
  assign w_sm1       = r_state - 4'd1;
  assign w_step      = w_legal ? w_sm1[3:1] : 3'd0;
  assign w_req_fire  = w_is_req  && i_mul_req_ready;
  assign w_resp_fire = w_is_wait && i_mul_resp_valid;

  assign o_mul_req_valid  = w_is_req;
  assign o_mul_req_a      = w_is_req ? r_coef[w_step] : '0;
  assign o_mul_req_b      = w_is_req ? r_sigma2       : '0;
  assign o_mul_resp_ready = w_is_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_coef   <= '0;
      r_q      <= '0;
      r_sigma2 <= '0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (i_start && i_coef_valid) begin
          r_sigma2 <= i_sigma2;
          r_coef   <= {i_dt2, i_half_dt3, i_quarter_dt4,
                       i_sixth_dt4, i_twleve_dt5, i_thirtysix_dt6};
          r_valid  <= 1'b0;
          r_state  <= S_REQ_Q00;
        end
      end else if (!w_legal) begin
        r_state <= S_IDLE;
      end else if (w_req_fire) begin
        r_state <= state_t'(r_state + 4'd1);
      end else if (w_resp_fire) begin
        r_q[w_step] <= i_mul_resp_y;
        if (r_state == S_WAIT_Q22) begin
          r_valid <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_state <= state_t'(r_state + 4'd1);
        end
      end
    end
  end

  assign o_q00   = r_q[0];
  assign o_q01   = r_q[1];
  assign o_q10   = r_q[1];
  assign o_q02   = r_q[2];
  assign o_q20   = r_q[2];
  assign o_q11   = r_q[3];
  assign o_q12   = r_q[4];
  assign o_q21   = r_q[4];
  assign o_q22   = r_q[5];
  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_process_noise_q_builder.sv
// Directed + randomized bench: ideal FP64 multiplier with fixed latency, expected Q
// computed from dt and sigma2 as sigma2 * G_i * G_j.
module tb_process_noise_q_builder;
  localparam int DW  = 64;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DW-1:0] sigma2 = '0;
  logic [DW-1:0] cf [6];
  logic          req_ready = 1'b1;
  logic          req_valid, resp_ready, done, busy, valid;
  logic [DW-1:0] req_a, req_b;
  logic          model_rv = 1'b0;
  logic          spur = 1'b0;
  logic [DW-1:0] model_y = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_y;
  logic [DW-1:0] q00, q01, q02, q10, q11, q12, q20, q21, q22;

  assign resp_valid = model_rv | spur;
  assign resp_y     = spur ? 64'hBADB_ADBA_DBAD_BADB : model_y;

  always #5 clk = ~clk;

  process_noise_q_builder #(.DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_coef_valid(coef_valid),
    .i_sigma2(sigma2), .i_thirtysix_dt6(cf[0]), .i_twleve_dt5(cf[1]),
    .i_sixth_dt4(cf[2]), .i_quarter_dt4(cf[3]), .i_half_dt3(cf[4]), .i_dt2(cf[5]),
    .o_mul_req_valid(req_valid), .i_mul_req_ready(req_ready),
    .o_mul_req_a(req_a), .o_mul_req_b(req_b),
    .i_mul_resp_valid(resp_valid), .o_mul_resp_ready(resp_ready), .i_mul_resp_y(resp_y),
    .o_q00(q00), .o_q01(q01), .o_q02(q02), .o_q10(q10), .o_q11(q11), .o_q12(q12),
    .o_q20(q20), .o_q21(q21), .o_q22(q22),
    .o_done(done), .o_busy(busy), .o_valid(valid)
  );

  // Handshakes sampled at the active edge, acted on by the model at the falling edge
  logic          p_req = 1'b0, p_resp = 1'b0;
  logic [DW-1:0] p_a = '0, p_b = '0;
  always @(posedge clk) begin
    p_req  <= req_valid && req_ready;
    p_resp <= resp_valid && resp_ready;
    p_a    <= req_a;
    p_b    <= req_b;
  end

  logic [DW-1:0] obs_a[$];
  logic [DW-1:0] obs_b[$];
  int            mcnt = 0;
  logic          pend = 1'b0;
  logic [DW-1:0] prod = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend     = 1'b0;
      model_rv = 1'b0;
    end else begin
      if (p_resp) model_rv = 1'b0;
      if (p_req) begin
        obs_a.push_back(p_a);
        obs_b.push_back(p_b);
        prod = $realtobits($bitstoreal(p_a) * $bitstoreal(p_b));
        pend = 1'b1;
        mcnt = LAT;
      end else if (pend) begin
        mcnt--;
        if (mcnt == 0) begin
          pend     = 1'b0;
          model_rv = 1'b1;
          model_y  = prod;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // G = [dt^3/6, dt^2/2, dt]; returns G_i*G_j
  function automatic real gg(input int i, input int j, input real dt);
    real p;
    real d [3];
    d = '{6.0, 2.0, 1.0};
    p = 1.0;
    for (int k = 0; k < 6 - i - j; k++) p = p * dt;
    return p / (d[i] * d[j]);
  endfunction

  task automatic set_inputs(input real dt, input real s);
    sigma2 = $realtobits(s);
    cf[0] = $realtobits(gg(0, 0, dt));
    cf[1] = $realtobits(gg(0, 1, dt));
    cf[2] = $realtobits(gg(0, 2, dt));
    cf[3] = $realtobits(gg(1, 1, dt));
    cf[4] = $realtobits(gg(1, 2, dt));
    cf[5] = $realtobits(gg(2, 2, dt));
  endtask

  task automatic check_q(input string tag, input real dt, input real s);
    logic [DW-1:0] ob [3][3];
    ob = '{'{q00, q01, q02}, '{q10, q11, q12}, '{q20, q21, q22}};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s_q%0d%0d", tag, i, j), ob[i][j], $realtobits(s * gg(i, j, dt)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_q00"}, q00, '0); chk({tag, "_q01"}, q01, '0); chk({tag, "_q02"}, q02, '0);
    chk({tag, "_q10"}, q10, '0); chk({tag, "_q11"}, q11, '0); chk({tag, "_q12"}, q12, '0);
    chk({tag, "_q20"}, q20, '0); chk({tag, "_q21"}, q21, '0); chk({tag, "_q22"}, q22, '0);
    chk({tag, "_done"}, 64'(done), '0);
    chk({tag, "_valid"}, 64'(valid), '0);
    chk({tag, "_busy"}, 64'(busy), '0);
    chk({tag, "_resp_ready"}, 64'(resp_ready), '0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_build(input string tag, input real dt, input real s, input int stall,
                           input bit pulse_q11, input bit spur_en, input bit abort);
    int            base, n, ndone, tail, stl;
    bit            pulsed, fin, vchk;
    logic [DW-1:0] old_q00;
    set_inputs(dt, s);
    coef_valid = 1'b1;
    base = obs_a.size();
    ndone = 0; tail = 0; stl = stall; pulsed = 0; fin = 0; vchk = 0;
    old_q00 = q00;
    if (spur_en) begin
      spur = 1'b1;
      tick();
      chk({tag, "_spur_idle_ready"}, 64'(resp_ready), '0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      n = obs_a.size() - base;
      if (spur) begin
        if (n == 0) begin
          chk({tag, "_spur_req_ready"}, 64'(resp_ready), '0);
          chk({tag, "_spur_q00"}, q00, old_q00);
        end else spur = 1'b0;
      end
      if (!vchk && n == 3) begin
        chk({tag, "_valid_low_in_build"}, 64'(valid), '0);
        vchk = 1;
      end
      if (req_valid && n == 2 && stl > 0) begin
        req_ready = 1'b0;
        chk({tag, "_stall_a"}, req_a, cf[2]);
        chk({tag, "_stall_b"}, req_b, sigma2);
        stl--;
      end else req_ready = 1'b1;
      if (pulse_q11 && !pulsed && resp_ready && n == 4) begin
        start  = 1'b1;
        pulsed = 1;
      end else start = 1'b0;
      if (abort && resp_ready && n == 5) begin
        rst_n = 1'b0;
        #1;
        check_zero({tag, "_abort"});
        fin = 1;
      end
      if (done) ndone++;
      if (ndone > 0) begin
        tail++;
        if (tail > 3) fin = 1;
      end
      if (!fin) tick();
    end
    start = 1'b0;
    req_ready = 1'b1;
    spur = 1'b0;
    if (abort) begin
      tick(); tick();
      chk({tag, "_abort_hold_ready"}, 64'(resp_ready), '0);
      rst_n = 1'b1;
      tick();
    end else begin
      chk({tag, "_done_count"}, 64'(ndone), 64'd1);
      chk({tag, "_txn_count"}, 64'(obs_a.size() - base), 64'd6);
      for (int k = 0; k < 6 && base + k < obs_a.size(); k++) begin
        chk($sformatf("%s_op_a%0d", tag, k), obs_a[base + k], cf[k]);
        chk($sformatf("%s_op_b%0d", tag, k), obs_b[base + k], sigma2);
      end
      chk({tag, "_valid"}, 64'(valid), 64'd1);
      chk({tag, "_busy"}, 64'(busy), '0);
      check_q(tag, dt, s);
      if (stall > 0) chk({tag, "_stall_used"}, 64'(stl), '0);
    end
  endtask

  initial begin
    int  base;
    real dt, s;
    for (int k = 0; k < 6; k++) cf[k] = '0;
    repeat (3) tick();
    check_zero("reset");
    chk("reset_req_valid", 64'(req_valid), '0);
    rst_n = 1'b1;
    tick();

    // Start without coef_valid must not launch anything
    set_inputs(1.0, 2.0);
    base = obs_a.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("gate_busy", 64'(busy), '0);
    chk("gate_req_valid", 64'(req_valid), '0);
    chk("gate_txn", 64'(obs_a.size() - base), '0);

    run_build("nominal", 1.0, 2.0, 0, 0, 1, 0);
    chk("nominal_q22", q22, 64'h4000000000000000);
    chk("nominal_q12", q12, 64'h3FF0000000000000);
    chk("nominal_q21", q21, 64'h3FF0000000000000);
    chk("nominal_q11", q11, 64'h3FE0000000000000);
    repeat (3) tick();
    chk("nominal_valid_hold", 64'(valid), 64'd1);

    run_build("backpressure", 1.0, 2.0, 5, 0, 0, 0);
    run_build("start_in_wait", 0.5, 3.0, 0, 1, 0, 0);
    run_build("abort", 1.5, 1.25, 0, 0, 0, 1);
    run_build("after_abort", 2.0, 0.5, 0, 0, 0, 0);
    chk("after_abort_q22", q22, 64'h4000000000000000);

    for (int r = 0; r < 4; r++) begin
      dt = real'($urandom_range(1, 24)) / 8.0;
      s  = real'($urandom_range(1, 40)) / 4.0;
      run_build($sformatf("rand%0d", r), dt, s, int'($urandom_range(0, 3)), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
